// File: rtl/inv_mix_columns_iter.sv
// AES InvMixColumns with valid/ready handshakes: one column per cycle by default.
// Define INV_MIX_COLUMNS_PARALLEL_EN to transform all four columns in a single COMPUTE cycle.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   work, work_n;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
  logic [1:0]      cnt, cnt_n;
  logic [1:0]      col_idx;
`endif

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column; row 0 sits in the top byte.
  function automatic logic [CW-1:0] inv_col(input logic [CW-1:0] c);
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[CW-1-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifndef INV_MIX_COLUMNS_PARALLEL_EN
  // Column 0 lives in the top word of the state.
  assign col_idx = 2'd3 - cnt;
`endif

  // Next-state and working-register update.
  always_comb begin
    state_n = state;
    work_n  = work;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_n  = in_data;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
          cnt_n   = 2'd0;
`endif
          state_n = COMPUTE;
        end
      end
      COMPUTE: begin
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
        for (int c = 0; c < 4; c++) begin
          work_n[CW*c +: CW] = inv_col(work[CW*c +: CW]);
        end
        state_n = DONE;
`else
        work_n[{col_idx, 5'b0} +: CW] = inv_col(work[{col_idx, 5'b0} +: CW]);
        if (cnt == 2'd3) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt + 2'd1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; handshake flags are decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
      cnt       <= 2'd0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
      cnt       <= cnt_n;
`endif
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  assign out_data = work;

endmodule
